// File: rtl/pdm_pkg.sv
// Shared constants and arithmetic helpers for the PDM audio DAC.
package pdm_pkg;

  localparam logic ORDER1 = 1'b0;
  localparam logic ORDER2 = 1'b1;

  // Offset-binary zero level for a given sample width.
  function automatic logic [31:0] midscale(input int width);
    return 32'd1 << (width - 1);
  endfunction

  // Clamp to the symmetric range of an iw-bit signed integrator.
  function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int iw);
    logic signed [31:0] lim;
    lim = (32'sd1 <<< (iw - 1)) - 32'sd1;
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

endpackage

// File: rtl/pdm_channel_mod.sv
// One PDM channel: sample conditioning (sign, volume, mute) and a
// first-order accumulator or second-order saturating modulator.
module pdm_channel_mod
  import pdm_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int IW    = WIDTH + 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en_i,
  input  logic             order2_i,
  input  logic             signed_i,
  input  logic             mute_i,
  input  logic [2:0]       vol_i,
  input  logic [WIDTH-1:0] sample_i,
  output logic             pdm_o
);

  logic [WIDTH-1:0]        acc_q;
  logic signed [IW-1:0]    i1_q, i2_q;
  logic                    pdm_q, order_q;

  logic signed [WIDTH-1:0] sh;
  logic [WIDTH-1:0]        u_s;
  logic [WIDTH:0]          sum1;
  logic signed [31:0]      fb, i1_sum, i1_nx, i2_sum, i2_nx;

  always_comb begin
    // Arithmetic shift of the two's complement value, then back to offset binary.
    sh = $signed(sample_i) >>> vol_i;
    if (mute_i)        u_s = signed_i ? WIDTH'(midscale(WIDTH)) : '0;
    else if (signed_i) u_s = {~sh[WIDTH-1], sh[WIDTH-2:0]};
    else               u_s = sample_i >> vol_i;

    sum1   = {1'b0, acc_q} + {1'b0, u_s};

    fb     = pdm_q ? (32'sd1 <<< WIDTH) : 32'sd0;
    i1_sum = 32'(i1_q) + $signed({{(32-WIDTH){1'b0}}, u_s}) - fb;
    i1_nx  = sat(i1_sum, IW);
    i2_sum = 32'(i2_q) + i1_nx - fb;
    i2_nx  = sat(i2_sum, IW);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      acc_q   <= '0;
      i1_q    <= '0;
      i2_q    <= '0;
      pdm_q   <= 1'b0;
      order_q <= ORDER1;
    end else begin
      order_q <= order2_i;
      if (!en_i) begin
        acc_q <= '0;
        i1_q  <= '0;
        i2_q  <= '0;
        pdm_q <= 1'b0;
      end else if (order2_i != order_q) begin
        // Mode change restarts from a clean state; the output bit is held.
        acc_q <= '0;
        i1_q  <= '0;
        i2_q  <= '0;
      end else if (order2_i == ORDER2) begin
        i1_q  <= IW'(i1_nx);
        i2_q  <= IW'(i2_nx);
        pdm_q <= (i2_nx >= 0);
      end else begin
        acc_q <= sum1[WIDTH-1:0];
        pdm_q <= sum1[WIDTH];
      end
    end
  end

  assign pdm_o = pdm_q;

endmodule

// File: rtl/pdm_audio_dac.sv
// Multi-channel PDM DAC: pending/active sample buffers with valid/ready intake,
// sample-rate transfer strobe, sticky underrun flag and per-channel modulators.
module pdm_audio_dac
  import pdm_pkg::*;
#(
  parameter int WIDTH    = 12,
  parameter int CHANNELS = 2,
  parameter int IW       = WIDTH + 4
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      en_i,
  input  logic                      order2_i,
  input  logic                      signed_i,
  input  logic                      mute_i,
  input  logic [2:0]                vol_i,
  input  logic [CHANNELS*WIDTH-1:0] sample_i,
  input  logic                      sample_valid_i,
  output logic                      sample_ready_o,
  input  logic                      update_i,
  output logic [CHANNELS-1:0]       pdm_o,
  output logic                      sd_o,
  output logic                      underrun_o,
  input  logic                      underrun_clr_i
);

  logic [CHANNELS*WIDTH-1:0] pend_q, pend_d, act_q, act_d;
  logic                      pend_full_q, pend_full_d;
  logic                      underrun_q, underrun_d;
  logic                      sd_q;
  logic                      accept;

  always_comb begin
    accept      = sample_valid_i & ~pend_full_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    act_d       = act_q;
    underrun_d  = underrun_q;
    if (underrun_clr_i) underrun_d = 1'b0;
    if (update_i) begin
      if (pend_full_q) begin
        act_d       = pend_q;
        pend_full_d = 1'b0;
      end else if (accept) begin
        act_d = sample_i;
      end else begin
        // Strobe with nothing to play: keep the old sample, flag it (beats clear).
        underrun_d = 1'b1;
      end
    end else if (accept) begin
      pend_d      = sample_i;
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      act_q       <= '0;
      underrun_q  <= 1'b0;
      sd_q        <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      act_q       <= act_d;
      underrun_q  <= underrun_d;
      sd_q        <= en_i;
    end
  end

  assign sample_ready_o = ~pend_full_q;
  assign underrun_o     = underrun_q;
  assign sd_o           = sd_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    pdm_channel_mod #(
      .WIDTH (WIDTH),
      .IW    (IW)
    ) u_ch (
      .clk_i    (clk_i),
      .rstn_i   (rstn_i),
      .en_i     (en_i),
      .order2_i (order2_i),
      .signed_i (signed_i),
      .mute_i   (mute_i),
      .vol_i    (vol_i),
      .sample_i (act_q[c*WIDTH +: WIDTH]),
      .pdm_o    (pdm_o[c])
    );
  end

endmodule

// File: tb/tb_pdm_audio_dac.sv
// Self-checking bench for pdm_audio_dac: directed handshake/underrun/reset
// checks plus randomized density checks against an arithmetic reference.
module tb_pdm_audio_dac;

  localparam int W  = 12;
  localparam int CH = 2;

  logic            clk = 1'b0;
  logic            rstn, en, order2, sgn, mute, upd, vld, clr;
  logic [2:0]      vol;
  logic [CH*W-1:0] sample;
  logic            rdy, sd, urun;
  logic [CH-1:0]   pdm;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pdm_audio_dac #(.WIDTH(W), .CHANNELS(CH), .IW(W + 4)) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .en_i           (en),
    .order2_i       (order2),
    .signed_i       (sgn),
    .mute_i         (mute),
    .vol_i          (vol),
    .sample_i       (sample),
    .sample_valid_i (vld),
    .sample_ready_o (rdy),
    .update_i       (upd),
    .pdm_o          (pdm),
    .sd_o           (sd),
    .underrun_o     (urun),
    .underrun_clr_i (clr)
  );

  task automatic check(input string tag, input int obs, input int exp, input int tol = 0);
    checks++;
    if (obs < exp - tol || obs > exp + tol) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference conditioning: the level each channel should reproduce, in 1/4096 units.
  function automatic int exp_us(input int s, input bit sg, input int v, input bit m);
    int x;
    if (m) return sg ? 2048 : 0;
    if (!sg) return s >> v;
    x = (s >= 2048) ? s - 4096 : s;
    return (x >>> v) + 2048;
  endfunction

  // Bypass load: pending must be empty; word goes straight to active.
  task automatic load(input int a, input int b);
    sample = {b[W-1:0], a[W-1:0]};
    vld = 1'b1;
    upd = 1'b1;
    tick();
    vld = 1'b0;
    upd = 1'b0;
  endtask

  task automatic measure(input int n, output int o0, output int o1, output int tg);
    logic p;
    o0 = 0;
    o1 = 0;
    tg = 0;
    p  = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      o0 += int'(pdm[0]);
      o1 += int'(pdm[1]);
      if (i > 0 && pdm[0] != p) tg++;
      p = pdm[0];
    end
  endtask

  task automatic run2(input int s0, input int s1, input bit sg, input int v);
    int o0, o1, tg;
    order2 = 1'b0;
    sgn    = sg;
    vol    = 3'(v);
    tick();
    order2 = 1'b1;
    load(s0, s1);
    measure(4096, o0, o1, tg);
    check("ord2_ch0", o0, exp_us(s0, sg, v, 1'b0), 4);
    check("ord2_ch1", o1, exp_us(s1, sg, v, 1'b0), 4);
  endtask

  initial begin
    int o0, o1, tg;
    int s0, s1, v;
    bit sg, m;

    rstn = 1'b0; en = 1'b0; order2 = 1'b0; sgn = 1'b0; mute = 1'b0;
    vol = 3'd0; upd = 1'b0; vld = 1'b0; clr = 1'b0; sample = '0;
    #12 rstn = 1'b1;
    tick();

    en = 1'b1;
    load(12'h800, 12'h400);
    measure(16, o0, o1, tg);
    check("o1_800_ones", o0, 8);
    check("o1_800_alt", tg, 15);
    check("o1_400_ones", o1, 4);

    // Fill pending, then reset mid-stream.
    sample = {12'hC00, 12'hC00};
    vld = 1'b1;
    tick();
    vld = 1'b0;
    check("pend_full_rdy", int'(rdy), 0);
    #3 rstn = 1'b0;
    #1;
    check("rst_pdm", int'(pdm), 0);
    check("rst_sd", int'(sd), 0);
    check("rst_rdy", int'(rdy), 1);
    check("rst_urun", int'(urun), 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    check("sd_after_rst", int'(sd), 1);
    upd = 1'b1;
    tick();
    upd = 1'b0;
    check("rst_first_upd_urun", int'(urun), 1);
    measure(16, o0, o1, tg);
    check("rst_active_zero", o0 + o1, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("urun_clr", int'(urun), 0);

    // Handshake: A held in pending, B refused until A moves to active.
    sample = {12'h800, 12'h800};
    vld = 1'b1;
    tick();
    check("hs_A_rdy", int'(rdy), 0);
    sample = {12'hC00, 12'hC00};
    tick();
    check("hs_B_refused", int'(rdy), 0);
    upd = 1'b1;
    tick();
    upd = 1'b0;
    check("hs_upd_rdy", int'(rdy), 1);
    tick();
    vld = 1'b0;
    check("hs_B_accepted", int'(rdy), 0);
    measure(16, o0, o1, tg);
    check("hs_A_active", o0, 8);
    check("hs_no_urun", int'(urun), 0);
    upd = 1'b1;
    tick();
    upd = 1'b0;
    check("hs_B_moved_rdy", int'(rdy), 1);
    measure(16, o0, o1, tg);
    check("hs_B_active", o0, 12);

    // Bypass with strobe and accept in the same cycle.
    load(12'h400, 12'h400);
    check("byp_rdy", int'(rdy), 1);
    check("byp_urun", int'(urun), 0);
    measure(16, o0, o1, tg);
    check("byp_active", o0, 4);

    // Underrun: repeated strobes keep the active value.
    upd = 1'b1;
    repeat (3) tick();
    upd = 1'b0;
    check("ur_set", int'(urun), 1);
    measure(16, o0, o1, tg);
    check("ur_active_held", o0, 4);
    clr = 1'b1;
    tick();
    check("ur_clr_alone", int'(urun), 0);
    upd = 1'b1;
    tick();
    check("ur_set_wins", int'(urun), 1);
    upd = 1'b0;
    tick();
    clr = 1'b0;

    load(0, 0);
    measure(16, o0, o1, tg);
    check("o1_zero", o0 + o1, 0);

    sgn = 1'b1;
    load(0, 0);
    measure(16, o0, o1, tg);
    check("signed_zero_alt", tg, 15);

    mute = 1'b1;
    load(12'h7FF, 12'h7FF);
    measure(16, o0, o1, tg);
    check("mute_alt", tg, 15);
    mute = 1'b0;

    vol = 3'd1;
    load(12'h7FE, 12'h7FE);
    measure(4096, o0, o1, tg);
    check("vol1_7FE", o0, 3071, 1);

    // Randomized first-order conditioning vs reference level.
    for (int k = 0; k < 6; k++) begin
      s0 = int'($urandom_range(0, 4095));
      s1 = int'($urandom_range(0, 4095));
      v  = int'($urandom_range(0, 7));
      sg = 1'($urandom_range(0, 1));
      m  = ($urandom_range(0, 5) == 0);
      sgn = sg;
      vol = 3'(v);
      mute = m;
      load(s0, s1);
      measure(4096, o0, o1, tg);
      check("rnd_o1_ch0", o0, exp_us(s0, sg, v, m), 1);
      check("rnd_o1_ch1", o1, exp_us(s1, sg, v, m), 1);
    end
    mute = 1'b0;

    // Second order: directed extremes, then randomized levels.
    run2(12'h300, 12'hFFF, 1'b0, 0);
    order2 = 1'b0;
    tick();
    order2 = 1'b1;
    load(0, 12'hFFF);
    measure(4096, o0, o1, tg);
    check("ord2_zero_max16", o0, 8, 8);
    check("ord2_full_min4080", o1, 4088, 8);
    for (int k = 0; k < 2; k++) begin
      run2(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
    end

    en = 1'b0;
    check("en_drop_sd_before", int'(sd), 1);
    tick();
    check("en_drop_pdm", int'(pdm), 0);
    check("en_drop_sd", int'(sd), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
